// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer driving a combinational 1-bit ALU slice, LSB first, with carry fed back between bits.
// Optional status flags (zero/neg/ovf) are built when ALU_SEQ_FLAGS_EN is defined.
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             sl_a,
    output logic             sl_b,
    output logic             sl_cin,
    output logic [2:0]       sl_op,
    input  logic             sl_r,
    input  logic             sl_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_err
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // S_ERR spends the one cycle an illegal request takes before DONE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               err_q, err_d;
    logic               arith_q;
    logic               in_illegal;
    logic               run;
    logic               done;

`ifdef ALU_SEQ_FLAGS_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
`endif

    assign arith_q    = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign in_illegal = (in_op == 3'b110) || (in_op == 3'b111);
    assign in_ready   = (state_q == S_IDLE) && rst_n;
    assign run        = (state_q == S_RUN) && rst_n;
    assign done       = (state_q == S_DONE) && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            op_q    <= OP_MOV;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        if (state_q == S_IDLE && in_valid) begin
            a_msb_d = in_a[WIDTH-1];
            b_msb_d = in_b[WIDTH-1];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d = in_a;
                    b_sh_d = in_b;
                    res_d  = '0;
                    op_d   = in_op;
                    cnt_d  = '0;
                    if (in_illegal) begin
                        carry_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        // Subtract is a + ~b + 1, so the carry chain starts at 1.
                        carry_d = (in_op == OP_SUB);
                        err_d   = 1'b0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                res_d   = {sl_r, res_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = arith_q ? sl_cout : 1'b0;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                end
            end
            S_ERR: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sl_a   = run ? a_sh_q[0] : 1'b0;
        sl_b   = run ? b_sh_q[0] : 1'b0;
        sl_cin = run ? carry_q : 1'b0;
        sl_op  = run ? op_q : OP_MOV;
    end

    assign out_valid  = done;
    assign out_result = rst_n ? res_q : '0;
    assign out_carry  = done && !err_q && arith_q && carry_q;
    assign out_err    = done && err_q;

`ifdef ALU_SEQ_FLAGS_EN
    logic flag_ok;
    assign flag_ok  = done && !err_q;
    assign out_zero = flag_ok && (res_q == '0);
    assign out_neg  = flag_ok && res_q[WIDTH-1];
    always_comb begin
        out_ovf = 1'b0;
        if (flag_ok && op_q == OP_ADD) begin
            out_ovf = (a_msb_q == b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
        end else if (flag_ok && op_q == OP_SUB) begin
            out_ovf = (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
        end
    end
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl (WIDTH=8) with a behavioural 1-bit ALU slice model.
// Flag checks are compiled in when ALU_SEQ_FLAGS_EN is defined.
module tb_alu_serial_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             sl_a;
    logic             sl_b;
    logic             sl_cin;
    logic [2:0]       sl_op;
    logic             sl_r;
    logic             sl_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_err;
`ifdef ALU_SEQ_FLAGS_EN
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .sl_a       (sl_a),
        .sl_b       (sl_b),
        .sl_cin     (sl_cin),
        .sl_op      (sl_op),
        .sl_r       (sl_r),
        .sl_cout    (sl_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_err    (out_err)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_ovf    (out_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-bit ALU slice: sub is a + ~b + cin.
    logic [1:0] sum2;
    always_comb begin
        sl_r    = 1'b0;
        sl_cout = 1'b0;
        sum2    = 2'b00;
        case (sl_op)
            3'b000: sl_r = sl_a;
            3'b001: sl_r = ~sl_a;
            3'b010: begin
                sum2    = {1'b0, sl_a} + {1'b0, sl_b} + {1'b0, sl_cin};
                sl_r    = sum2[0];
                sl_cout = sum2[1];
            end
            3'b011: begin
                sum2    = {1'b0, sl_a} + {1'b0, ~sl_b} + {1'b0, sl_cin};
                sl_r    = sum2[0];
                sl_cout = sum2[1];
            end
            3'b100: sl_r = sl_a | sl_b;
            3'b101: sl_r = sl_a & sl_b;
            default: sl_r = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request; returns once the accept edge has passed.
    task automatic start_op(input string tag, input logic [2:0] op,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_out(input string tag, input logic [WIDTH-1:0] res, input logic carry,
                             input logic err, input logic [2:0] zno);
        chk({tag, ".valid"},  32'(out_valid),  32'd1);
        chk({tag, ".result"}, 32'(out_result), 32'(res));
        chk({tag, ".carry"},  32'(out_carry),  32'(carry));
        chk({tag, ".err"},    32'(out_err),    32'(err));
`ifdef ALU_SEQ_FLAGS_EN
        chk({tag, ".flags"}, 32'({out_zero, out_neg, out_ovf}), 32'(zno));
`else
        if (zno === 3'bxxx) $display("unreachable");
`endif
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".drop"},  32'(out_valid), 32'd0);
        chk({tag, ".ready"}, 32'(in_ready),  32'd1);
    endtask

    // Full transaction; zno = {zero, neg, ovf}.
    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] res, input logic carry, input logic [2:0] zno);
        start_op(tag, op, a, b);
        chk({tag, ".sl_op"},  32'(sl_op),  32'(op));
        chk({tag, ".sl_cin"}, 32'(sl_cin), 32'(op == 3'b011));
        wait_done(tag, WIDTH);
        check_out(tag, res, carry, 1'b0, zno);
        release_out(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'b000;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst.in_ready",  32'(in_ready),  32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result",    32'(out_result), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel.in_ready", 32'(in_ready), 32'd1);
        chk("rel.sl_op",    32'(sl_op),    32'd0);

        do_op("add_7f_01", 3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 3'b011);
        do_op("sub_05_07", 3'b011, 8'h05, 8'h07, 8'hFE, 1'b0, 3'b010);
        do_op("sub_07_05", 3'b011, 8'h07, 8'h05, 8'h02, 1'b1, 3'b000);
        do_op("sub_80_01", 3'b011, 8'h80, 8'h01, 8'h7F, 1'b1, 3'b001);
        do_op("add_ff_01", 3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 3'b100);
        do_op("mov_f0",    3'b000, 8'hF0, 8'h3C, 8'hF0, 1'b0, 3'b010);
        do_op("not_a5",    3'b001, 8'hA5, 8'h00, 8'h5A, 1'b0, 3'b000);
        do_op("or_f0_3c",  3'b100, 8'hF0, 8'h3C, 8'hFC, 1'b0, 3'b010);
        do_op("and_f0_3c", 3'b101, 8'hF0, 8'h3C, 8'h30, 1'b0, 3'b000);

        // Illegal op, then hold the result with out_ready low while a new request waits.
        start_op("ill110", 3'b110, 8'h12, 8'h34);
        chk("ill110.sl_op", 32'(sl_op), 32'd0);
        wait_done("ill110", 1);
        check_out("ill110", 8'h00, 1'b0, 1'b1, 3'b000);
        in_op    = 3'b010;
        in_a     = 8'h55;
        in_b     = 8'h11;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("hold", 8'h00, 1'b0, 1'b1, 3'b000);
            chk("hold.in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_out("ill110");

        start_op("ill111", 3'b111, 8'hFF, 8'hFF);
        wait_done("ill111", 1);
        check_out("ill111", 8'h00, 1'b0, 1'b1, 3'b000);
        release_out("ill111");

        // Reset while bit 3 of an add is on the slice.
        start_op("abort", 3'b010, 8'h0F, 8'h01);
        tick();
        tick();
        tick();
        chk("abort.sl_op", 32'(sl_op), 32'd2);
        rst_n = 1'b0;
        tick();
        chk("abort.in_ready_low", 32'(in_ready),  32'd0);
        chk("abort.valid_low",    32'(out_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        chk("abort.no_valid", 32'(seen), 32'd0);

        do_op("add_01_01", 3'b010, 8'h01, 8'h01, 8'h02, 1'b0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
